// File: rtl/cpu_pkg.sv
// Shared definitions for the sequencer and the instruction decoder:
// 3-bit state encoding, opcode/special-op constants and the control bundle.
package cpu_pkg;

  localparam int INSTR_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  // Major opcode lives in instr[8:6]; instr[5:0] is operand or special-op field.
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ST   = 3'd2;
  localparam logic [2:0] OP_BEQ  = 3'd3;
  localparam logic [2:0] OP_JMP  = 3'd4;
  localparam logic [2:0] OP_SWAP = 3'd5;
  localparam logic [2:0] OP_SYS  = 3'd7;

  localparam logic [5:0] SP_NOP  = 6'h00;
  localparam logic [5:0] SP_HALT = 6'h3F;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
    logic reg_write;
    logic swap_ctrl;
    logic done_ctrl;
    logic jmp_ctrl;
  } ctrl_t;

  // Reference decode of one instruction word into sequencer control lines.
  function automatic ctrl_t decode(input logic [INSTR_W-1:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[8:6])
      OP_ADD:  c.reg_write = 1'b1;
      OP_LD:   begin c.mem_read = 1'b1; c.reg_write = 1'b1; end
      OP_ST:   c.mem_write = 1'b1;
      OP_BEQ:  c.branch    = 1'b1;
      OP_JMP:  c.jmp_ctrl  = 1'b1;
      OP_SWAP: c.swap_ctrl = 1'b1;
      OP_SYS:  c.done_ctrl = (instr[5:0] == SP_HALT);
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_pc_unit.sv
// Program counter register with next-PC selection: start load, jump,
// taken branch, or sequential increment wrapping at 2^PC_W.
module cpu_pc_unit #(
  parameter int PC_W = 10
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_start_addr,
  input  logic            i_advance,
  input  logic            i_jmp,
  input  logic            i_branch,
  input  logic            i_taken,
  input  logic [PC_W-1:0] i_target,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;

  // Next-PC priority: start load, then jump, then taken branch, then pc+1.
  always_comb begin
    // NOTE: default assigned first so every path drives w_pc_next and no latch is inferred.
    w_pc_next = r_pc;
    if (i_load) begin
      w_pc_next = i_start_addr;
    end else if (i_advance) begin
      if (i_jmp)                     w_pc_next = i_target;
      else if (i_branch && i_taken)  w_pc_next = i_target;
      else                           w_pc_next = r_pc + 1'b1;
    end
  end

  // PC register.
  always_ff @(posedge i_clock) begin
    // NOTE: reset is sampled on the clock edge (synchronous), and state uses <= so
    // every flop sees pre-edge values regardless of block ordering.
    if (!i_reset_n) r_pc <= '0;
    else            r_pc <= w_pc_next;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/writeback control
// with instruction register, retired counter and handshake strobes.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [8:0]       imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             branch,
  input  logic             reg_write,
  input  logic             swap_ctrl,
  input  logic             done_ctrl,
  input  logic             jmp_ctrl,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  target_addr,
  output logic [PC_W-1:0]  pc,
  output logic [8:0]       instr,
  output logic             reg_we,
  output logic             swap_we,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_state_next;
  logic [8:0]       r_instr;
  logic [CNT_W-1:0] r_retired;
  logic             w_load_start;
  logic             w_advance;

  cpu_pc_unit #(.PC_W(PC_W)) u_pc (
    .i_clock      (clock),
    .i_reset_n    (reset_n),
    .i_load       (w_load_start),
    .i_start_addr (start_addr),
    .i_advance    (w_advance),
    .i_jmp        (jmp_ctrl),
    .i_branch     (branch),
    .i_taken      (branch_taken),
    .i_target     (target_addr),
    .o_pc         (pc)
  );

  // Next-state and Moore/handshake outputs; acks only matter in their own state.
  always_comb begin
    w_state_next = r_state;
    w_load_start = 1'b0;
    w_advance    = 1'b0;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_we       = 1'b0;
    swap_we      = 1'b0;
    halted       = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_load_start = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_state_next = ST_DECODE;
      end
      ST_DECODE: w_state_next = done_ctrl ? ST_HALT : ST_EXEC;
      ST_EXEC:   w_state_next = (mem_read || mem_write) ? ST_MEM : ST_WB;
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_write;
        if (dmem_ack) w_state_next = ST_WB;
      end
      ST_WB: begin
        reg_we       = reg_write & ~mem_write;
        swap_we      = swap_ctrl;
        w_advance    = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (start) begin
          w_load_start = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      default: begin
        busy         = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Instruction register, captured on the accepted fetch.
  always_ff @(posedge clock) begin
    if (!reset_n)                          r_instr <= '0;
    else if (r_state == ST_FETCH && imem_ack) r_instr <= imem_rdata;
  end

  // Retired-instruction counter, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (!reset_n)                                r_retired <= '0;
    else if (r_state == ST_WB && r_retired != '1) r_retired <= r_retired + 1'b1;
  end

  assign imem_addr = pc;
  assign instr     = r_instr;
  assign retired   = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a program is laid out in instruction
// memory, expected per-instruction outcomes are queued, and a monitor pops
// and compares each time an instruction retires or the core halts.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start;
  logic [PC_W-1:0]  start_addr;
  logic             imem_req, imem_ack;
  logic [PC_W-1:0]  imem_addr;
  logic [8:0]       imem_rdata;
  logic             dmem_req, dmem_we, dmem_ack;
  logic             mem_read, mem_write, branch, reg_write, swap_ctrl, done_ctrl, jmp_ctrl;
  logic             branch_taken;
  logic [PC_W-1:0]  target_addr;
  logic [PC_W-1:0]  pc;
  logic [8:0]       instr;
  logic             reg_we, swap_we, halted, busy;
  logic [CNT_W-1:0] retired;

  cpu_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .reg_write(reg_write),
    .swap_ctrl(swap_ctrl), .done_ctrl(done_ctrl), .jmp_ctrl(jmp_ctrl),
    .branch_taken(branch_taken), .target_addr(target_addr),
    .pc(pc), .instr(instr), .reg_we(reg_we), .swap_we(swap_we),
    .halted(halted), .busy(busy), .retired(retired)
  );

  always #5 clock = ~clock;

  // ---------------- environment: memories and decoder ----------------
  logic [8:0]      prog      [0:1023];
  int              iwait_mem [0:1023];
  int              dwait_mem [0:1023];
  logic            taken_mem [0:1023];
  logic [PC_W-1:0] tgt_mem   [0:1023];
  ctrl_t           force_mem [0:1023];
  int              iwaited = 0;
  int              dwaited = 0;
  logic            force_dack;
  ctrl_t           w_ctrl;

  assign imem_rdata = prog[imem_addr];
  assign imem_ack   = imem_req && (iwaited >= iwait_mem[imem_addr]);
  assign dmem_ack   = (dmem_req && (dwaited >= dwait_mem[pc])) || force_dack;

  always @(posedge clock) begin
    iwaited <= (imem_req && !imem_ack) ? iwaited + 1 : 0;
    dwaited <= (dmem_req && !dmem_ack) ? dwaited + 1 : 0;
  end

  always_comb begin
    w_ctrl = ctrl_t'(decode(instr) | force_mem[pc]);
  end

  assign mem_read     = w_ctrl.mem_read;
  assign mem_write    = w_ctrl.mem_write;
  assign branch       = w_ctrl.branch;
  assign reg_write    = w_ctrl.reg_write;
  assign swap_ctrl    = w_ctrl.swap_ctrl;
  assign done_ctrl    = w_ctrl.done_ctrl;
  assign jmp_ctrl     = w_ctrl.jmp_ctrl;
  assign branch_taken = taken_mem[pc];
  assign target_addr  = tgt_mem[pc];

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] ret;
    logic             halted;
    int cyc, ireq, dreq, dwe, rwe, rwe_cyc, swe;
    logic [PC_W-1:0]  faddr;
  } exp_t;

  exp_t exp_q[$];

  task automatic push(input logic [PC_W-1:0] p, input logic [CNT_W-1:0] r, input logic h,
                      input int cyc, input int ireq, input int dreq, input int dwe,
                      input int rwe, input int rwe_cyc, input int swe,
                      input logic [PC_W-1:0] fa);
    exp_t e;
    e.pc = p; e.ret = r; e.halted = h; e.cyc = cyc; e.ireq = ireq; e.dreq = dreq;
    e.dwe = dwe; e.rwe = rwe; e.rwe_cyc = rwe_cyc; e.swe = swe; e.faddr = fa;
    exp_q.push_back(e);
  endtask

  // Monitor: per-instruction activity counters, compared on retire or halt.
  int c_cyc = 0, c_ireq = 0, c_dreq = 0, c_dwe = 0, c_rwe = 0, c_rwe_cyc = 0, c_swe = 0;
  logic [CNT_W-1:0] prev_ret = '0;
  logic             prev_halt = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if ((retired == prev_ret + 1) || (halted && !prev_halt)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("pc",         pc,        e.pc);
          check("retired",    retired,   e.ret);
          check("halted",     halted,    e.halted);
          check("busy",       busy,      !e.halted);
          check("cycles",     c_cyc,     e.cyc);
          check("imem_req_n", c_ireq,    e.ireq);
          check("dmem_req_n", c_dreq,    e.dreq);
          check("dmem_we_n",  c_dwe,     e.dwe);
          check("reg_we_n",   c_rwe,     e.rwe);
          check("reg_we_cyc", c_rwe_cyc, e.rwe_cyc);
          check("swap_we_n",  c_swe,     e.swe);
        end
        c_cyc = 0; c_ireq = 0; c_dreq = 0; c_dwe = 0; c_rwe = 0; c_rwe_cyc = 0; c_swe = 0;
      end
      if (!busy) begin
        c_cyc = 0; c_ireq = 0; c_dreq = 0; c_dwe = 0; c_rwe = 0; c_rwe_cyc = 0; c_swe = 0;
      end else begin
        c_cyc++;
        if (imem_req) begin
          c_ireq++;
          if (exp_q.size() != 0) check("imem_addr", imem_addr, exp_q[0].faddr);
        end
        if (dmem_req) c_dreq++;
        if (dmem_we)  c_dwe++;
        if (reg_we) begin c_rwe++; c_rwe_cyc = c_cyc; end
        if (swap_we)  c_swe++;
      end
      prev_ret  = retired;
      prev_halt = halted;
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    ctrl_t store_force;
    for (int i = 0; i < 1024; i++) begin
      prog[i] = '0; iwait_mem[i] = 0; dwait_mem[i] = 0;
      taken_mem[i] = 1'b0; tgt_mem[i] = '0; force_mem[i] = '0;
    end
    reset_n = 1'b0; start = 1'b0; start_addr = '0; force_dack = 1'b0;

    // Program and expectations (pc, retired, halted, cycles, ireq, dreq, dwe, rwe, rwe_cyc, swe, fetch addr).
    prog[10'h010] = {OP_ADD, 6'h01};
    push(10'h011, 16'd1, 1'b0, 4, 1, 0, 0, 1, 4, 0, 10'h010);
    prog[10'h011] = {OP_ADD, 6'h02}; iwait_mem[10'h011] = 3;
    push(10'h012, 16'd2, 1'b0, 7, 4, 0, 0, 1, 7, 0, 10'h011);
    // Store with read and reg_write also raised: write must win, no reg_we.
    prog[10'h012] = {OP_ST, 6'h03}; dwait_mem[10'h012] = 2;
    store_force = '0; store_force.mem_read = 1'b1; store_force.reg_write = 1'b1;
    force_mem[10'h012] = store_force;
    push(10'h013, 16'd3, 1'b0, 7, 1, 3, 3, 0, 0, 0, 10'h012);
    prog[10'h013] = {OP_BEQ, 6'h00}; taken_mem[10'h013] = 1'b1; tgt_mem[10'h013] = 10'h005;
    push(10'h005, 16'd4, 1'b0, 4, 1, 0, 0, 0, 0, 0, 10'h013);
    prog[10'h005] = {OP_JMP, 6'h00}; tgt_mem[10'h005] = 10'h3FF;
    push(10'h3FF, 16'd5, 1'b0, 4, 1, 0, 0, 0, 0, 0, 10'h005);
    prog[10'h3FF] = {OP_ADD, 6'h04};
    push(10'h000, 16'd6, 1'b0, 4, 1, 0, 0, 1, 4, 0, 10'h3FF);
    prog[10'h000] = {OP_LD, 6'h05};
    push(10'h001, 16'd7, 1'b0, 5, 1, 1, 0, 1, 5, 0, 10'h000);
    prog[10'h001] = {OP_SWAP, 6'h06};
    push(10'h002, 16'd8, 1'b0, 4, 1, 0, 0, 0, 0, 1, 10'h001);
    prog[10'h002] = {OP_BEQ, 6'h00}; tgt_mem[10'h002] = 10'h100;
    push(10'h003, 16'd9, 1'b0, 4, 1, 0, 0, 0, 0, 0, 10'h002);
    prog[10'h003] = {OP_SYS, SP_HALT};
    push(10'h003, 16'd9, 1'b1, 2, 1, 0, 0, 0, 0, 0, 10'h003);
    prog[10'h020] = {OP_ADD, 6'h07};
    push(10'h021, 16'd10, 1'b0, 4, 1, 0, 0, 1, 4, 0, 10'h020);
    prog[10'h021] = {OP_LD, 6'h08}; dwait_mem[10'h021] = 100;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_pc",       pc,       0);
    check("rst_instr",    instr,    0);
    check("rst_retired",  retired,  0);
    check("rst_halted",   halted,   0);
    check("rst_busy",     busy,     0);
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_reg_we",   reg_we,   0);

    @(posedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1 start = 1'b1; start_addr = 10'h010;
    @(posedge clock); #1 start = 1'b0; start_addr = 10'h3A0;

    for (int i = 0; i < 300 && !halted; i++) @(negedge clock);
    check("halt_reached", halted, 1);
    repeat (5) @(negedge clock);
    check("halt_ret_hold", retired, 9);
    check("halt_busy",     busy,    0);
    check("halt_pc_hold",  pc,      10'h003);

    @(posedge clock); #1 start = 1'b1; start_addr = 10'h020;
    @(posedge clock); #1 start = 1'b0;

    for (int i = 0; i < 300 && !dmem_req; i++) @(negedge clock);
    check("mem_reached", dmem_req, 1);
    reset_n = 1'b0;
    @(negedge clock);
    check("mrst_dmem_req", dmem_req, 0);
    check("mrst_busy",     busy,     0);
    check("mrst_halted",   halted,   0);
    check("mrst_pc",       pc,       0);
    check("mrst_retired",  retired,  0);
    check("mrst_instr",    instr,    0);
    reset_n = 1'b1; force_dack = 1'b1;
    @(negedge clock);
    force_dack = 1'b0;
    repeat (2) @(negedge clock);
    check("late_ack_busy",     busy,     0);
    check("late_ack_dmem_req", dmem_req, 0);
    check("late_ack_pc",       pc,       0);
    check("late_ack_retired",  retired,  0);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
